// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic-array edge feeder.
// The optional stall statistics are enabled with SYSTOLIC_FEEDER_STATS_EN.
package systolic_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int N_DEF      = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_COLLECT = 3'd1,
    W_SHIFT   = 3'd2,
    STREAM    = 3'd3,
    DRAIN     = 3'd4
  } feeder_state_e;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// Per-row delay line for the activation wavefront; carries a valid bit with the data.
// DEPTH=0 degenerates to a wire.
module systolic_skew_line
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign data_o         = data_i;
      assign valid_o        = valid_i;
    end else begin : g_dly
      logic [DATA_W-1:0] data_q [DEPTH];
      logic [DEPTH-1:0]  valid_q;

      // Shift data and valid one stage per cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= {DATA_W{1'b0}};
          end
          valid_q <= {DEPTH{1'b0}};
        end else begin
          data_q[0]  <= data_i;
          valid_q[0] <= valid_i;
          for (int i = 1; i < DEPTH; i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign data_o  = data_q[DEPTH-1];
      assign valid_o = valid_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Edge feeder for an N x N systolic array: weight preload down the columns, skewed activations into the rows.
// Define SYSTOLIC_FEEDER_STATS_EN to add the saturating stall_cnt output.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N      = N_DEF,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_load_w,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [N*DATA_W-1:0] w_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [N*DATA_W-1:0] a_data,
  output logic [N*DATA_W-1:0] pe_data,
  output logic [N*DATA_W-1:0] pe_sum,
  output logic                pe_ld_weight,
  output logic [N-1:0]        pe_valid,
  output logic                done
`ifdef SYSTOLIC_FEEDER_STATS_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int W     = N * DATA_W;
  localparam int CNT_W = cnt_width(N);
  localparam int DRN_W = cnt_width(2 * N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(2 * N - 2);

  feeder_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DRN_W-1:0] drain_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] vcnt_q;
  logic [W-1:0]     wbuf_q [N];
  logic [W-1:0]     pe_data_q;
  logic [W-1:0]     pe_sum_q;
  logic             pe_ld_q;
  logic [N-1:0]     pe_valid_q;
  logic             done_q;

  logic             cmd_fire;
  logic             a_fire;
  logic             last_beat;
  logic [CNT_W-1:0] shift_idx;
  logic [W-1:0]     skew_in_data;
  logic [W-1:0]     skew_out_data;
  logic [N-1:0]     skew_in_valid;
  logic [N-1:0]     skew_out_valid;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign w_ready   = (state_q == W_COLLECT);
  assign a_ready   = (state_q == STREAM);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign a_fire    = a_valid && a_ready;
  assign last_beat = (vcnt_q == (len_q - LEN_W'(1)));
  // The newest row is driven straight from w_data, so shifting reads the buffer from row N-2 down.
  assign shift_idx = CNT_W'(N - 2) - cnt_q;

  // Accepted beats enter the skew lines; any other cycle injects a zero bubble.
  always_comb begin
    if (a_fire) begin
      skew_in_data  = a_data;
      skew_in_valid = {N{1'b1}};
    end else begin
      skew_in_data  = {W{1'b0}};
      skew_in_valid = {N{1'b0}};
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    systolic_skew_line #(
      .DATA_W (DATA_W),
      .DEPTH  (r)
    ) u_skew (
      .clk     (clk),
      .reset   (reset),
      .data_i  (skew_in_data[r*DATA_W +: DATA_W]),
      .valid_i (skew_in_valid[r]),
      .data_o  (skew_out_data[r*DATA_W +: DATA_W]),
      .valid_o (skew_out_valid[r])
    );
  end

  // Left-edge output register behind the skew lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      pe_data_q  <= {W{1'b0}};
      pe_valid_q <= {N{1'b0}};
    end else begin
      pe_data_q  <= skew_out_data;
      pe_valid_q <= skew_out_valid;
    end
  end

  // Command sequencer with registered weight-load outputs and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      drain_q  <= {DRN_W{1'b0}};
      len_q    <= {LEN_W{1'b0}};
      vcnt_q   <= {LEN_W{1'b0}};
      pe_sum_q <= {W{1'b0}};
      pe_ld_q  <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        wbuf_q[i] <= {W{1'b0}};
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            len_q   <= cmd_len;
            vcnt_q  <= {LEN_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            drain_q <= {DRN_W{1'b0}};
            if (cmd_load_w) begin
              state_q <= W_COLLECT;
            end else if (cmd_len == {LEN_W{1'b0}}) begin
              state_q <= DRAIN;
            end else begin
              state_q <= STREAM;
            end
          end
        end
        W_COLLECT: begin
          if (w_valid) begin
            wbuf_q[cnt_q] <= w_data;
            if (cnt_q == CNT_LAST) begin
              cnt_q    <= {CNT_W{1'b0}};
              pe_ld_q  <= 1'b1;
              pe_sum_q <= w_data;
              state_q  <= W_SHIFT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        W_SHIFT: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= {CNT_W{1'b0}};
            pe_ld_q  <= 1'b0;
            pe_sum_q <= {W{1'b0}};
            state_q  <= (len_q == {LEN_W{1'b0}}) ? DRAIN : STREAM;
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
            pe_sum_q <= wbuf_q[shift_idx];
          end
        end
        STREAM: begin
          if (a_fire) begin
            if (last_beat) begin
              vcnt_q  <= {LEN_W{1'b0}};
              state_q <= DRAIN;
            end else begin
              vcnt_q <= vcnt_q + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_q == DRN_LAST) begin
            drain_q <= {DRN_W{1'b0}};
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            drain_q <= drain_q + DRN_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pe_data      = pe_data_q;
  assign pe_sum       = pe_sum_q;
  assign pe_ld_weight = pe_ld_q;
  assign pe_valid     = pe_valid_q;
  assign done         = done_q;

`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [31:0] stall_q;

  // Saturating count of STREAM cycles that found no activation waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 32'd0;
    end else if (cmd_fire) begin
      stall_q <= 32'd0;
    end else if ((state_q == STREAM) && !a_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end else begin
      stall_q <= stall_q;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, DATA_W=32); expectations come from accept times seen by the bench.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int W  = N * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_load_w;
  logic [LW-1:0] cmd_len;
  logic          w_valid, w_ready, a_valid, a_ready;
  logic [W-1:0]  w_data, a_data, pe_data, pe_sum;
  logic          pe_ld_weight, done;
  logic [N-1:0]  pe_valid;
`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] rec_data  [64];
  logic [W-1:0] rec_sum   [64];
  logic [N-1:0] rec_valid [64];
  logic         rec_ld    [64];
  logic         rec_done  [64];
  logic         rec_crdy  [64];
  logic         rec_ardy  [64];
  int           a_acc     [16];
  int           w_last;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_W(DW), .N(N), .LEN_W(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load_w   (cmd_load_w),
    .cmd_len      (cmd_len),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .pe_data      (pe_data),
    .pe_sum       (pe_sum),
    .pe_ld_weight (pe_ld_weight),
    .pe_valid     (pe_valid),
    .done         (done)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Weight row k: lane c holds 4k+1+c.
  function automatic logic [W-1:0] wrow(input int k);
    logic [W-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = DW'(4 * k + 1 + c);
    return v;
  endfunction

  // Activation beat k: lane r holds 10(r+1)+100k, so beat 0 is {10,20,30,40}.
  function automatic logic [W-1:0] abeat(input int k);
    logic [W-1:0] v;
    for (int r = 0; r < N; r++) v[r*DW +: DW] = DW'(10 * (r + 1) + 100 * k);
    return v;
  endfunction

  task automatic check_idle_outputs(input string nm);
    check_eq({nm, "_pe_data"}, pe_data, {W{1'b0}});
    check_eq({nm, "_pe_sum"},  pe_sum,  {W{1'b0}});
    check_eq({nm, "_pe_ld"},   W'(pe_ld_weight), W'(1'b0));
    check_eq({nm, "_pe_valid"}, W'(pe_valid), W'(4'b0000));
    check_eq({nm, "_done"},    W'(done),    W'(1'b0));
    check_eq({nm, "_w_ready"}, W'(w_ready), W'(1'b0));
    check_eq({nm, "_a_ready"}, W'(a_ready), W'(1'b0));
  endtask

  // Issue one command, drive weights/activations with optional gap masks, and check the whole trace.
  task automatic run_cmd(input string nm, input logic lw, input int len,
                         input logic [63:0] wgap, input logic [63:0] agap, input int ncyc);
    int wk, ak, done_at, done_n, ld_n, sum_bad, ardy_n, t_done, vcnt;
    logic [W-1:0] exp_d, beat;
    logic [N-1:0] exp_v;
    wk = 0; ak = 0; w_last = -1;
    check_eq({nm, "_cmd_ready"}, W'(cmd_ready), W'(1'b1));
    cmd_valid = 1'b1; cmd_load_w = lw; cmd_len = LW'(len);
    step();
    cmd_valid = 1'b0;
`ifdef SYSTOLIC_FEEDER_STATS_EN
    check_eq({nm, "_stall_clr"}, W'(stall_cnt), W'(32'd0));
`endif
    for (int i = 0; i < ncyc; i++) begin
      w_valid = lw && (wk < N) && !wgap[i];
      w_data  = w_valid ? wrow(wk) : {W{1'b0}};
      a_valid = (ak < len) && !agap[i] && (!lw || wk == N);
      a_data  = a_valid ? abeat(ak) : {W{1'b0}};
      if (w_valid && w_ready) begin
        if (wk == N - 1) w_last = i;
        wk++;
      end
      if (a_valid && a_ready) begin
        a_acc[ak] = i;
        ak++;
      end
      rec_ardy[i] = a_ready;
      step();
      rec_data[i] = pe_data;  rec_sum[i]  = pe_sum;   rec_valid[i] = pe_valid;
      rec_ld[i]   = pe_ld_weight; rec_done[i] = done; rec_crdy[i] = cmd_ready;
    end
    w_valid = 1'b0; a_valid = 1'b0;

    check_eq({nm, "_beats"}, W'(ak), W'(len));
    ld_n = 0; sum_bad = 0; done_n = 0; done_at = -1; ardy_n = 0;
    for (int j = 0; j < ncyc; j++) begin
      if (rec_ld[j]) ld_n++;
      if (!rec_ld[j] && rec_sum[j] != {W{1'b0}}) sum_bad++;
      if (rec_done[j]) begin
        done_n++;
        if (done_at < 0) done_at = j;
      end
      if (rec_ardy[j]) ardy_n++;
    end
    check_eq({nm, "_ld_count"}, W'(ld_n), lw ? W'(N) : W'(0));
    check_eq({nm, "_sum_idle"}, W'(sum_bad), W'(0));
    if (lw) begin
      check_eq({nm, "_w_beats"}, W'(wk), W'(N));
      if (w_last >= 0) begin
        for (int j = 0; j < N; j++) begin
          check_eq($sformatf("%s_ld%0d", nm, j), W'(rec_ld[w_last + j]), W'(1'b1));
          check_eq($sformatf("%s_sum%0d", nm, j), rec_sum[w_last + j], wrow(N - 1 - j));
        end
      end
      if (len > 0 && ak > 0) begin
        check_eq({nm, "_ld_gap"}, W'(rec_ld[a_acc[0] - 1]), W'(1'b0));
      end
    end
    // Lane r of a beat accepted at edge t shows up r edges later.
    for (int j = 0; j < ncyc; j++) begin
      exp_d = {W{1'b0}};
      exp_v = {N{1'b0}};
      for (int k = 0; k < ak; k++) begin
        beat = abeat(k);
        for (int r = 0; r < N; r++) begin
          if (a_acc[k] + r == j) begin
            exp_d[r*DW +: DW] = beat[r*DW +: DW];
            exp_v[r] = 1'b1;
          end
        end
      end
      check_eq($sformatf("%s_data_c%0d", nm, j), rec_data[j], exp_d);
      check_eq($sformatf("%s_valid_c%0d", nm, j), W'(rec_valid[j]), W'(exp_v));
    end
    for (int r = 0; r < N; r++) begin
      vcnt = 0;
      for (int j = 0; j < ncyc; j++) if (rec_valid[j][r]) vcnt++;
      check_eq($sformatf("%s_lane%0d_slots", nm, r), W'(vcnt), W'(len));
    end
    if (len > 0) t_done = (ak > 0) ? a_acc[ak - 1] + 2 * N - 1 : -100;
    else if (lw) t_done = w_last + N + 2 * N - 1;
    else t_done = 2 * N - 2;
    check_eq({nm, "_done_n"}, W'(done_n), W'(1));
    check_eq({nm, "_done_at"}, W'(done_at), W'(t_done));
    if (done_at >= 0) check_eq({nm, "_idle_after"}, W'(rec_crdy[done_at]), W'(1'b1));
    if (len == 0) check_eq({nm, "_no_a_ready"}, W'(ardy_n), W'(0));
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_load_w = 1'b0; cmd_len = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    step(); step();
    check_idle_outputs("reset");
    reset = 1'b0;
    #1;
    check_eq("reset_cmd_ready", W'(cmd_ready), W'(1'b1));

    // Weight load with gaps and zero length: 4 collect beats, 4 ld cycles, 7 drain cycles.
    run_cmd("wload", 1'b1, 0, 64'h55, 64'h0, 24);
    // Single vector skew.
    run_cmd("skew", 1'b0, 1, 64'h0, 64'h0, 12);
    // Two bubbles between the first and second beat.
    run_cmd("bubble", 1'b0, 3, 64'h0, 64'h6, 16);
    // Zero length without weights drains straight away.
    run_cmd("zero", 1'b0, 0, 64'h0, 64'h0, 10);

    // Reset in the middle of the weight shift.
    cmd_valid = 1'b1; cmd_load_w = 1'b1; cmd_len = LW'(1);
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_valid = 1'b1; w_data = wrow(k);
      step();
    end
    w_valid = 1'b0;
    check_eq("rst_ld_first", W'(pe_ld_weight), W'(1'b1));
    step();
    check_eq("rst_ld_second", W'(pe_ld_weight), W'(1'b1));
    reset = 1'b1;
    step();
    check_idle_outputs("midreset");
    reset = 1'b0;
    #1;
    check_eq("midreset_cmd_ready", W'(cmd_ready), W'(1'b1));
    run_cmd("fresh", 1'b1, 2, 64'h0, 64'h0, 22);

`ifdef SYSTOLIC_FEEDER_STATS_EN
    run_cmd("stall", 1'b0, 2, 64'h0, 64'h3E, 18);
    check_eq("stall_cnt5", W'(stall_cnt), W'(32'd5));
    run_cmd("stall_next", 1'b0, 1, 64'h0, 64'h0, 12);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: activation and weight word width.
REQ-002 The block SHALL have parameter N, default 4: array rows and columns.
REQ-003 The block SHALL have parameter LEN_W, default 16: vector-count width.
REQ-004 The block SHALL have port clk, input, 1: clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 The block SHALL have ports cmd_valid, cmd_ready (in, out, 1 each) and cmd_load_w (in, 1): command handshake; cmd_load_w=1 reloads weights before streaming.
REQ-007 The block SHALL have port cmd_len, input, LEN_W: activation vectors to stream.
REQ-008 The block SHALL have ports w_valid (in, 1), w_ready (out, 1) and w_data (in, N*DATA_W): weight-row stream; lane c is column c.
REQ-009 The block SHALL have ports a_valid (in, 1), a_ready (out, 1) and a_data (in, N*DATA_W): activation-vector stream; lane r is row r.
REQ-010 The block SHALL have port pe_data, output, N*DATA_W: left-edge data, lane r drives row r.
REQ-011 The block SHALL have port pe_sum, output, N*DATA_W: top-edge sum/weight, lane c drives column c.
REQ-012 The block SHALL have port pe_ld_weight, output, 1: weight-load strobe to all PEs.
REQ-013 The block SHALL have port pe_valid, output, N: bit r high when pe_data lane r carries a real activation.
REQ-014 The block SHALL have port done, output, 1: one-cycle pulse at command completion.

Function
REQ-015 FSM states SHALL be IDLE, W_COLLECT, W_SHIFT, STREAM, DRAIN; cmd_ready=1 only in IDLE.
REQ-016 Command accepted with cmd_load_w=1 -> W_COLLECT; with cmd_load_w=0 -> STREAM, or DRAIN when cmd_len=0.
REQ-017 W_COLLECT: w_ready=1; each handshake stores one row into an N-row buffer; after the Nth beat -> W_SHIFT.
REQ-018 W_SHIFT: exactly N consecutive cycles, pe_ld_weight=1, pe_sum = buffer rows in reverse arrival order (last beat first), so beat k lands in PE row k; never interrupted.
REQ-019 After W_SHIFT: -> STREAM if cmd_len>0, else -> DRAIN; pe_ld_weight SHALL be 0 for at least one cycle before the first valid activation.
REQ-020 STREAM: a_ready=1; beat accepted at edge t SHALL appear on pe_data lane r at cycle t+1+r, pe_valid[r]=1 alongside.
REQ-021 STREAM cycle without a_valid: a zero bubble with pe_valid=0 SHALL enter the skew lines; no stall of already-issued lanes.
REQ-022 After cmd_len accepted beats -> DRAIN; the vector counter SHALL be LEN_W wide with no wrap within a command.
REQ-023 DRAIN: exactly 2N-1 cycles, a_ready=0; skew lines flush with zeros; then done=1 for one cycle and -> IDLE.
REQ-024 Outside W_SHIFT, pe_sum SHALL be 0 and pe_ld_weight 0; all pe_* outputs SHALL be registered.
REQ-025 w_ready SHALL be 0 outside W_COLLECT; a_ready SHALL be 0 outside STREAM.

Reset
REQ-026 On reset, including mid-command: state=IDLE; pe_data, pe_sum, pe_valid, skew lines, counters =0; pe_ld_weight=0; done=0; w_ready=a_ready=0; cmd_ready=1 the cycle after release; any partial command is discarded.

Configuration
REQ-027 With SYSTOLIC_FEEDER_STATS_EN defined, the block SHALL add output stall_cnt (32 bits): counts STREAM cycles with a_valid=0, cleared on reset and on command accept, saturating at all-ones.
REQ-028 Without SYSTOLIC_FEEDER_STATS_EN, the stall_cnt port and its logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-029 Package systolic_pkg SHALL hold the FSM state enum typedef and the default DATA_W/N constants.
REQ-030 Sub-module systolic_skew_line (parameter DEPTH, carries data plus valid) SHALL implement each per-row delay; row r uses DEPTH=r, and DEPTH=0 is a pass-through.

Verification (N=4, DATA_W=32)
REQ-031 Weight load: rows {1,2,3,4},{5..8},{9..12},{13..16} with w_valid gaps -> 4 contiguous pe_ld_weight cycles, pe_sum order row3,row2,row1,row0.
REQ-032 Skew: cmd_load_w=0, cmd_len=1, a_data={10,20,30,40} accepted at t -> pe_data lane r = {10,20,30,40}[r] at t+1+r, pe_valid one-hot per lane.
REQ-033 Bubble: cmd_len=3, a_valid low for 2 cycles between beats 1 and 2 -> two zero slots with pe_valid=0 on every lane, 3 valid slots per lane, done pulse exactly 7 cycles after the last accept.
REQ-034 Zero length: cmd_load_w=1, cmd_len=0 -> 4 collect beats, 4 ld cycles, 7 DRAIN cycles, one done pulse, no a_ready.
REQ-035 Reset mid-W_SHIFT after 2 ld cycles -> pe_ld_weight=0 and all outputs 0 next cycle; a fresh command then completes normally.
REQ-036 With SYSTOLIC_FEEDER_STATS_EN: 5 idle STREAM cycles -> stall_cnt=5; a new command accept -> 0.
